// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory controller.
// Size encodings, FSM states and byte-enable generation.
package data_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mem_state_t;

    function automatic logic [3:0] be_gen(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic [3:0] be;
        be = 4'b0000;
        unique case (size)
            SZ_BYTE: be = 4'b0001 << addr_lo;
            SZ_HALF: be = 4'b0011 << addr_lo;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic mis;
        mis = 1'b0;
        unique case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = addr_lo[0];
            SZ_WORD: mis = |addr_lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_ram.sv
// Word-wide RAM with per-byte write enables.
// Read and write are both registered on the rising edge.
module byte_lane_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // Lane-masked write plus registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Multi-cycle load/store controller with wait states.
// Stalls the core until the access completes; loads return right-justified.
module data_mem_ctrl
    import data_mem_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReq,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic [31:0] ReadData,
    output logic        ReadValid,
    output logic        MisalignFault
);

    localparam int AW = $clog2(DEPTH);

    mem_state_t    state_q, state_d;
    logic [3:0]    cnt_q;
    logic          wr_q;
    logic [1:0]    size_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;

    logic          mis;
    logic          accept;
    logic          commit;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;
    logic [4:0]    shamt;
    logic          unused_addr;

    assign unused_addr = ^Addr[31:AW+2];

    assign mis    = is_misaligned(Size, Addr[1:0]);
    assign accept = (state_q == IDLE) && MemReq && !mis;
    assign commit = (state_q == BUSY) && (cnt_q == 4'd0);
    assign shamt  = {addr_q[1:0], 3'b000};

    // In IDLE the RAM already reads the incoming word so data is ready in BUSY.
    assign ram_addr = (state_q == IDLE) ? Addr[AW+1:2] : addr_q[AW+1:2];

    byte_lane_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (commit && wr_q),
        .be    (be_gen(size_q, addr_q[1:0])),
        .addr  (ram_addr),
        .wdata (wdata_q << shamt),
        .rdata (ram_rdata)
    );

    // State register, wait counter and latched request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            wr_q    <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q   <= 4'(WAIT_STATES);
                wr_q    <= MemWrite;
                size_q  <= Size;
                addr_q  <= Addr[AW+1:0];
                wdata_q <= WriteData;
            end else if (state_q == BUSY && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
        end
    end

    // Load result is captured on the completing edge and held until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadData <= 32'd0;
        end else if (commit && !wr_q) begin
            ReadData <= ram_rdata >> shamt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d       = state_q;
        Stall         = 1'b0;
        ReadValid     = 1'b0;
        MisalignFault = 1'b0;
        unique case (state_q)
            IDLE: begin
                MisalignFault = MemReq && mis;
                Stall         = MemReq && !mis;
                if (accept) state_d = BUSY;
            end
            BUSY: begin
                Stall = MemReq;
                if (cnt_q == 4'd0) state_d = DONE;
            end
            DONE: begin
                ReadValid = !wr_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed table-driven bench for data_mem_ctrl.
// Adds hand-written sequences for reset, dropped request and back-to-back.
module tb_data_mem_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemReq;
    logic        MemWrite;
    logic [1:0]  Size;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        Stall;
    logic [31:0] ReadData;
    logic        ReadValid;
    logic        MisalignFault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .DEPTH       (1024),
        .WAIT_STATES (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .MemReq        (MemReq),
        .MemWrite      (MemWrite),
        .Size          (Size),
        .Addr          (Addr),
        .WriteData     (WriteData),
        .Stall         (Stall),
        .ReadData      (ReadData),
        .ReadValid     (ReadValid),
        .MisalignFault (MisalignFault)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stalls;
        int          valids;
        int          faults;
        logic [31:0] rdata;
        logic [31:0] mask;
    } vec_t;

    vec_t vt [17];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        MemReq    = 1'b1;
        MemWrite  = wr;
        Size      = sz;
        Addr      = a;
        WriteData = wd;
    endtask

    // Holds the request until Stall drops, counting what was seen.
    task automatic run_access(input logic wr, input logic [1:0] sz,
                              input logic [31:0] a, input logic [31:0] wd,
                              output int ns, output int nv, output int nf,
                              output logic [31:0] rd);
        logic done;
        done = 1'b0;
        ns = 0;
        nv = 0;
        nf = 0;
        rd = 32'd0;
        drive(wr, sz, a, wd);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (Stall) ns++;
            else done = 1'b1;
            if (ReadValid) nv++;
            if (MisalignFault) nf++;
            rd = ReadData;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: Stall stuck high, expected low");
        end
        @(posedge clk);
        #1;
        MemReq = 1'b0;
    endtask

    initial begin
        int          ns, nv, nf;
        int          v1, v2, nval;
        logic [31:0] rd;

        rst_n     = 1'b0;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        Size      = 2'b00;
        Addr      = 32'd0;
        WriteData = 32'd0;

        //            wr    size   addr        wdata         st   v  f  rdata         mask
        vt[0]  = '{1'b1, 2'b10, 32'h10,   32'hF00FF00F, W+2, 0, 0, 32'h00000000, 32'hFFFFFFFF};
        vt[1]  = '{1'b0, 2'b10, 32'h10,   32'h0,        W+2, 1, 0, 32'hF00FF00F, 32'hFFFFFFFF};
        vt[2]  = '{1'b1, 2'b00, 32'h13,   32'h000000AA, W+2, 0, 0, 32'hF00FF00F, 32'hFFFFFFFF};
        vt[3]  = '{1'b0, 2'b10, 32'h10,   32'h0,        W+2, 1, 0, 32'hAA0FF00F, 32'hFFFFFFFF};
        vt[4]  = '{1'b0, 2'b01, 32'h12,   32'h0,        W+2, 1, 0, 32'h0000AA0F, 32'h0000FFFF};
        vt[5]  = '{1'b0, 2'b00, 32'h11,   32'h0,        W+2, 1, 0, 32'h000000F0, 32'h000000FF};
        vt[6]  = '{1'b0, 2'b01, 32'h11,   32'h0,        0,   0, 1, 32'h00000000, 32'h00000000};
        vt[7]  = '{1'b0, 2'b10, 32'h12,   32'h0,        0,   0, 1, 32'h00000000, 32'h00000000};
        vt[8]  = '{1'b1, 2'b11, 32'h10,   32'hDEADBEEF, 0,   0, 1, 32'h00000000, 32'h00000000};
        vt[9]  = '{1'b0, 2'b10, 32'h10,   32'h0,        W+2, 1, 0, 32'hAA0FF00F, 32'hFFFFFFFF};
        vt[10] = '{1'b1, 2'b10, 32'h14,   32'h11223344, W+2, 0, 0, 32'hAA0FF00F, 32'hFFFFFFFF};
        vt[11] = '{1'b1, 2'b01, 32'h16,   32'hFFFFBEEF, W+2, 0, 0, 32'hAA0FF00F, 32'hFFFFFFFF};
        vt[12] = '{1'b0, 2'b10, 32'h14,   32'h0,        W+2, 1, 0, 32'hBEEF3344, 32'hFFFFFFFF};
        vt[13] = '{1'b0, 2'b00, 32'h17,   32'h0,        W+2, 1, 0, 32'h000000BE, 32'h000000FF};
        vt[14] = '{1'b0, 2'b10, 32'h4010, 32'h0,        W+2, 1, 0, 32'hAA0FF00F, 32'hFFFFFFFF};
        vt[15] = '{1'b1, 2'b00, 32'h4010, 32'h12345655, W+2, 0, 0, 32'hAA0FF00F, 32'hFFFFFFFF};
        vt[16] = '{1'b0, 2'b10, 32'h10,   32'h0,        W+2, 1, 0, 32'hAA0FF055, 32'hFFFFFFFF};

        @(negedge clk);
        chk("reset Stall", {31'd0, Stall}, 32'd0);
        chk("reset ReadValid", {31'd0, ReadValid}, 32'd0);
        chk("reset MisalignFault", {31'd0, MisalignFault}, 32'd0);
        chk("reset ReadData", ReadData, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 17; i++) begin
            run_access(vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata,
                       ns, nv, nf, rd);
            chk($sformatf("row%0d stalls", i), 32'(ns), 32'(vt[i].stalls));
            chk($sformatf("row%0d valids", i), 32'(nv), 32'(vt[i].valids));
            chk($sformatf("row%0d faults", i), 32'(nf), 32'(vt[i].faults));
            if (vt[i].mask != 32'd0)
                chk($sformatf("row%0d rdata", i), rd & vt[i].mask,
                    vt[i].rdata);
        end

        // lb result through sign/zero extension.
        run_access(1'b0, 2'b00, 32'h11, 32'h0, ns, nv, nf, rd);
        chk("lb sext", {{24{rd[7]}}, rd[7:0]}, 32'hFFFFFFF0);
        chk("lbu zext", {24'd0, rd[7:0]}, 32'h000000F0);

        // Store completes even when MemReq drops during BUSY.
        drive(1'b1, 2'b10, 32'h24, 32'h0BADF00D);
        @(posedge clk);
        #1;
        MemReq = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        run_access(1'b0, 2'b10, 32'h24, 32'h0, ns, nv, nf, rd);
        chk("dropped req store", rd, 32'h0BADF00D);

        // Held request is re-accepted right after DONE.
        v1 = -1;
        v2 = -1;
        nval = 0;
        drive(1'b0, 2'b10, 32'h24, 32'h0);
        for (int c = 0; c < 2 * (W + 3); c++) begin
            @(negedge clk);
            if (ReadValid) begin
                nval++;
                if (v1 < 0) v1 = c;
                else v2 = c;
            end
        end
        @(posedge clk);
        #1;
        MemReq = 1'b0;
        chk("b2b valid count", 32'(nval), 32'd2);
        chk("b2b first valid", 32'(v1), 32'(W + 2));
        chk("b2b second valid", 32'(v2), 32'(2 * W + 5));

        // Reset during BUSY drops a pending store.
        run_access(1'b1, 2'b10, 32'h20, 32'hCAFEBABE, ns, nv, nf, rd);
        run_access(1'b0, 2'b10, 32'h20, 32'h0, ns, nv, nf, rd);
        chk("pre-reset load", rd, 32'hCAFEBABE);
        drive(1'b1, 2'b10, 32'h20, 32'h12345678);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        MemReq = 1'b0;
        #1;
        chk("midreset Stall", {31'd0, Stall}, 32'd0);
        chk("midreset ReadValid", {31'd0, ReadValid}, 32'd0);
        chk("midreset ReadData", ReadData, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_access(1'b0, 2'b10, 32'h20, 32'h0, ns, nv, nf, rd);
        chk("store aborted", rd, 32'hCAFEBABE);
        chk("post-reset stalls", 32'(ns), 32'(W + 2));

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
